// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and data access.
// Data has fixed priority; a watchdog aborts a service that never sees MemReady.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IReqF,
    input  logic [31:0] IAddrF,
    output logic [31:0] IRdataF,
    output logic        IDoneF,
    input  logic        DReqM,
    input  logic        DWeM,
    input  logic [31:0] DAddrM,
    input  logic [31:0] DWdataM,
    output logic [31:0] DRdataM,
    output logic        DDoneM,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    input  logic        MemReady,
    output logic        StallIF,
    output logic        StallMem,
    output logic        MemErr
);

    typedef enum logic [1:0] {IDLE, SERV_I, SERV_D} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wdog;
    logic             elig_i, elig_d;
    logic             fin_ok, fin_to;

    // A request whose Done pulse is out this cycle is still high but already served.
    assign elig_i   = IReqF & ~IDoneF;
    assign elig_d   = DReqM & ~DDoneM;
    assign StallIF  = IReqF & ~IDoneF;
    assign StallMem = DReqM & ~DDoneM;

    always_comb begin
        state_nxt = state;
        fin_ok    = 1'b0;
        fin_to    = 1'b0;
        case (state)
            IDLE: begin
                if (elig_d)
                    state_nxt = SERV_D;
                else if (elig_i)
                    state_nxt = SERV_I;
            end
            SERV_I, SERV_D: begin
                // MemReady wins over a timeout landing on the same edge.
                if (MemReady) begin
                    fin_ok    = 1'b1;
                    state_nxt = IDLE;
                end else if (wdog == CNT_W'(TIMEOUT - 1)) begin
                    fin_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wdog     <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
            IRdataF  <= '0;
            DRdataM  <= '0;
            IDoneF   <= 1'b0;
            DDoneM   <= 1'b0;
            MemErr   <= 1'b0;
        end else begin
            state  <= state_nxt;
            IDoneF <= 1'b0;
            DDoneM <= 1'b0;
            if (state == IDLE) begin
                wdog <= '0;
                if (state_nxt == SERV_D) begin
                    MemReq   <= 1'b1;
                    MemWe    <= DWeM;
                    MemAddr  <= DAddrM;
                    MemWdata <= DWdataM;
                end else if (state_nxt == SERV_I) begin
                    MemReq   <= 1'b1;
                    MemWe    <= 1'b0;
                    MemAddr  <= IAddrF;
                    MemWdata <= '0;
                end
            end else if (fin_ok || fin_to) begin
                MemReq <= 1'b0;
                wdog   <= '0;
                if (state == SERV_I) begin
                    IDoneF  <= 1'b1;
                    IRdataF <= fin_ok ? MemRdata : 32'h0;
                end else begin
                    DDoneM <= 1'b1;
                    // A store leaves the load-data register untouched.
                    if (!MemWe)
                        DRdataM <= fin_ok ? MemRdata : 32'h0;
                end
                if (fin_to)
                    MemErr <= 1'b1;
            end else begin
                wdog <= wdog + CNT_W'(1);
            end
        end
    end

endmodule
